// File: rtl/sample_collector_pkg.sv
// Shared definitions for the sample collector: EBI register offsets, FSM encoding, FIFO entry width.
// SAMPLE_TIMESTAMP_EN widens entries to {scan_count, sample} and adds the TS register.
package sample_collector_pkg;

   localparam logic [3:0] OFF_CTRL    = 4'd0;
   localparam logic [3:0] OFF_PERIOD  = 4'd1;
   localparam logic [3:0] OFF_NCH     = 4'd2;
   localparam logic [3:0] OFF_CHPUSH  = 4'd3;
   localparam logic [3:0] OFF_LEVEL   = 4'd4;
   localparam logic [3:0] OFF_STATUS  = 4'd5;
   localparam logic [3:0] OFF_DATA_LO = 4'd6;
   localparam logic [3:0] OFF_DATA_HI = 4'd7;
   localparam logic [3:0] OFF_TS      = 4'd8;

`ifdef SAMPLE_TIMESTAMP_EN
   localparam int unsigned ENTRY_W  = 48;
   localparam int unsigned NUM_REGS = 9;
`else
   localparam int unsigned ENTRY_W  = 32;
   localparam int unsigned NUM_REGS = 8;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POLL = 2'd1,
      CAPT = 2'd2
   } state_e;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock FIFO with registered storage and a fall-through head; a pop on a full FIFO frees
// the slot for a push in the same cycle, and clear flushes the contents immediately.
module sample_fifo #(
   parameter int unsigned AW = 10,
   parameter int unsigned DW = 32
) (
   input  logic          sys_clk,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   input  logic          clear,
   output logic [DW-1:0] head,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          do_push, do_pop;

   assign empty   = (level_q == '0);
   assign full    = level_q[AW];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop) & ~clear;
   assign head    = mem[rd_ptr_q];
   assign level   = level_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/sample_collector.sv
// Polls a host-programmed channel list once per sample period and queues the returned samples for
// the MCU over the EBI window. Define SAMPLE_TIMESTAMP_EN to tag each entry with its scan number.
module sample_collector
   import sample_collector_pkg::*;
#(
   parameter int unsigned POSITION = 300,
   parameter int unsigned MAX_CH   = 16,
   parameter int unsigned FIFO_AW  = 10
) (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [18:0] addr,
   input  logic        wr,
   input  logic        re,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        output_sample,
   output logic [7:0]  channel_select,
   input  logic [31:0] sample_data
);

   localparam int unsigned CW = $clog2(MAX_CH + 1);
   localparam int unsigned LW = $clog2(MAX_CH);

   logic [18:0]         off;
   logic                hit, wr_hit, rd_hi;
   logic                wr_prev_q, rd_prev_q;
   logic                wr_stb, pop_stb, clear_stb;
   logic                run_q, run_d;
   logic [15:0]         period_q, period_d;
   logic [CW-1:0]       nch_q, nch_d;
   logic [7:0]          list_q [MAX_CH];
   logic [7:0]          list_d [MAX_CH];
   logic                ovf_q, ovf_d;
   logic [15:0]         timer_q, timer_d, eff_period;
   logic                timer_run, tick;
   state_e              state_q, state_d;
   logic [CW-1:0]       idx_q, idx_d, scan_n_q, scan_n_d;
   logic                output_sample_q, output_sample_d;
   logic [7:0]          channel_select_q, channel_select_d;
   logic                fifo_push, overrun;
   logic [ENTRY_W-1:0]  fifo_wdata, head;
   logic [FIFO_AW:0]    level;
   logic                full, empty;
`ifdef SAMPLE_TIMESTAMP_EN
   logic [15:0]         scan_cnt_q, scan_cnt_d;
   assign fifo_wdata = {scan_cnt_q, sample_data};
`else
   assign fifo_wdata = sample_data;
`endif

   // Offsets below POSITION wrap to huge values, so one compare covers both window bounds.
   assign off       = addr - 19'(POSITION);
   assign hit       = (off < 19'(NUM_REGS));
   assign wr_hit    = wr & enable & hit;
   assign rd_hi     = re & enable & hit & (off[3:0] == OFF_DATA_HI);
   assign wr_stb    = wr_hit & ~wr_prev_q;
   assign pop_stb   = rd_hi & ~rd_prev_q;
   assign clear_stb = wr_stb & (off[3:0] == OFF_CTRL) & data_in[1];

   assign eff_period = (period_q < 16'd2) ? 16'd1 : period_q;
   assign timer_run  = run_q & (nch_q != '0);
   assign tick       = timer_run & (timer_q == eff_period - 16'd1);
   assign timer_d    = (!timer_run || tick) ? 16'd0 : timer_q + 16'd1;

   always_comb begin
      run_d    = run_q;
      period_d = period_q;
      nch_d    = nch_q;
      list_d   = list_q;
      if (wr_stb) begin
         case (off[3:0])
            OFF_CTRL: begin
               run_d = data_in[0];
               if (data_in[2]) nch_d = '0;
            end
            OFF_PERIOD: period_d = data_in;
            OFF_CHPUSH: begin
               if (nch_q < CW'(MAX_CH)) begin
                  list_d[nch_q[LW-1:0]] = data_in[7:0];
                  nch_d = nch_q + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // The scan length is latched at the tick so list edits only affect the next scan.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      scan_n_d  = scan_n_q;
      fifo_push = 1'b0;
`ifdef SAMPLE_TIMESTAMP_EN
      scan_cnt_d = scan_cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (tick) begin
               state_d  = POLL;
               idx_d    = '0;
               scan_n_d = nch_q;
`ifdef SAMPLE_TIMESTAMP_EN
               scan_cnt_d = scan_cnt_q + 16'd1;
`endif
            end
         end
         POLL: state_d = CAPT;
         CAPT: begin
            fifo_push = 1'b1;
            if (idx_q + CW'(1) >= scan_n_q) begin
               state_d = IDLE;
            end else begin
               idx_d   = idx_q + CW'(1);
               state_d = POLL;
            end
         end
         default: state_d = IDLE;
      endcase
      overrun          = tick & (state_q != IDLE);
      output_sample_d  = (state_d == POLL);
      channel_select_d = (state_d == POLL) ? list_q[idx_d[LW-1:0]] : 8'd0;
   end

   always_comb begin
      ovf_d = ovf_q;
      if (clear_stb) begin
         ovf_d = 1'b0;
      end else if (overrun || (fifo_push && full && !(pop_stb && !empty))) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         wr_prev_q        <= 1'b0;
         rd_prev_q        <= 1'b0;
         run_q            <= 1'b0;
         period_q         <= '0;
         nch_q            <= '0;
         list_q           <= '{default: '0};
         ovf_q            <= 1'b0;
         timer_q          <= '0;
         state_q          <= IDLE;
         idx_q            <= '0;
         scan_n_q         <= '0;
         output_sample_q  <= 1'b0;
         channel_select_q <= '0;
`ifdef SAMPLE_TIMESTAMP_EN
         scan_cnt_q       <= '0;
`endif
      end else begin
         wr_prev_q        <= wr_hit;
         rd_prev_q        <= rd_hi;
         run_q            <= run_d;
         period_q         <= period_d;
         nch_q            <= nch_d;
         list_q           <= list_d;
         ovf_q            <= ovf_d;
         timer_q          <= timer_d;
         state_q          <= state_d;
         idx_q            <= idx_d;
         scan_n_q         <= scan_n_d;
         output_sample_q  <= output_sample_d;
         channel_select_q <= channel_select_d;
`ifdef SAMPLE_TIMESTAMP_EN
         scan_cnt_q       <= scan_cnt_d;
`endif
      end
   end

   assign output_sample  = output_sample_q;
   assign channel_select = channel_select_q;

   sample_fifo #(
      .AW(FIFO_AW),
      .DW(ENTRY_W)
   ) u_fifo (
      .sys_clk(sys_clk),
      .reset  (reset),
      .push   (fifo_push),
      .wdata  (fifo_wdata),
      .pop    (pop_stb),
      .clear  (clear_stb),
      .head   (head),
      .level  (level),
      .full   (full),
      .empty  (empty)
   );

   always_comb begin
      data_out = '0;
      if (re && enable && hit) begin
         case (off[3:0])
            OFF_CTRL:    data_out = {15'd0, run_q};
            OFF_PERIOD:  data_out = period_q;
            OFF_NCH:     data_out = 16'(nch_q);
            OFF_LEVEL:   data_out = 16'(level);
            OFF_STATUS:  data_out = {13'd0, ovf_q, full, empty};
            OFF_DATA_LO: data_out = empty ? 16'd0 : head[15:0];
            OFF_DATA_HI: data_out = empty ? 16'd0 : head[31:16];
`ifdef SAMPLE_TIMESTAMP_EN
            OFF_TS:      data_out = empty ? 16'd0 : head[47:32];
`endif
            default:     data_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_sample_collector.sv
// Randomized scoreboard bench for sample_collector: a producer model answers polls and queues the
// expected FIFO entries; a read monitor checks every DATA_HI pop against that queue.
`timescale 1ns/1ps
module tb_sample_collector;

   localparam int POS   = 300;
   localparam int DEPTH = 1024;

   logic        sys_clk = 1'b0;
   logic        reset   = 1'b1;
   logic        enable  = 1'b0;
   logic [18:0] addr    = '0;
   logic        wr      = 1'b0;
   logic        re      = 1'b0;
   logic [15:0] data_in = '0;
   logic [15:0] data_out;
   logic        output_sample;
   logic [7:0]  channel_select;
   logic [31:0] sample_data = '0;

   int          n_vec = 0;
   int          n_err = 0;
   logic [47:0] exp_q[$];
   logic [7:0]  ch_list[$];
   int          poll_k = 0;
   logic [15:0] scan_m = '0;
   bit          fixed_mode = 1'b0;
   logic        prev_os = 1'b0;
   logic        hi_prev = 1'b0;
   logic [15:0] lo_seen = '0;
`ifdef SAMPLE_TIMESTAMP_EN
   logic [15:0] ts_seen = '0;
`endif

   always #5 sys_clk = ~sys_clk;

   sample_collector #(
      .POSITION(POS),
      .MAX_CH  (16),
      .FIFO_AW (10)
   ) dut (
      .sys_clk       (sys_clk),
      .reset         (reset),
      .enable        (enable),
      .addr          (addr),
      .wr            (wr),
      .re            (re),
      .data_in       (data_in),
      .data_out      (data_out),
      .output_sample (output_sample),
      .channel_select(channel_select),
      .sample_data   (sample_data)
   );

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Producer: answers each poll and records what the FIFO should hold (capped at its depth).
   always @(negedge sys_clk) begin : producer
      logic [31:0] v;
      if (output_sample) begin
         check("strobe_spacing", 48'(prev_os), 48'd0);
         if (ch_list.size() > 0) begin
            check("channel_select", 48'(channel_select),
                  48'(ch_list[poll_k % ch_list.size()]));
            if (poll_k % ch_list.size() == 0) scan_m++;
         end
         poll_k++;
         if (fixed_mode) v = (channel_select == 8'd100) ? 32'hAAAA_0064 : 32'h0000_0003;
         else v = $urandom();
         sample_data = v;
         if (exp_q.size() < DEPTH) exp_q.push_back({scan_m, v});
      end
      prev_os = output_sample;
   end

   // Monitor: each rising DATA_HI read strobe is one popped entry (or an empty read).
   always @(negedge sys_clk) begin : read_mon
      logic        hi_now;
      logic [47:0] e;
      #2;
      hi_now = enable && re && (addr == 19'(POS + 7));
      if (enable && re && addr == 19'(POS + 6)) lo_seen = data_out;
`ifdef SAMPLE_TIMESTAMP_EN
      if (enable && re && addr == 19'(POS + 8)) ts_seen = data_out;
`endif
      if (hi_now && !hi_prev) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
`ifdef SAMPLE_TIMESTAMP_EN
            check("fifo_entry", {ts_seen, data_out, lo_seen}, e);
`else
            check("fifo_entry", {16'd0, data_out, lo_seen}, {16'd0, e[31:0]});
`endif
         end else begin
            check("empty_read", 48'(data_out), 48'd0);
         end
      end
      hi_prev = hi_now;
   end

   task automatic wr_reg(input int off, input logic [15:0] d);
      @(negedge sys_clk);
      enable = 1'b1; wr = 1'b1; addr = 19'(POS + off); data_in = d;
      @(negedge sys_clk);
      enable = 1'b0; wr = 1'b0;
   endtask

   task automatic rd_strobe(input int off);
      @(negedge sys_clk);
      enable = 1'b1; re = 1'b1; addr = 19'(POS + off);
      @(negedge sys_clk);
      enable = 1'b0; re = 1'b0;
   endtask

   task automatic expect_reg(input string name, input int off, input logic [15:0] exp);
      logic [15:0] d;
      @(negedge sys_clk);
      enable = 1'b1; re = 1'b1; addr = 19'(POS + off);
      #1 d = data_out;
      @(negedge sys_clk);
      enable = 1'b0; re = 1'b0;
      check(name, 48'(d), 48'(exp));
   endtask

   task automatic pop_entry();
`ifdef SAMPLE_TIMESTAMP_EN
      rd_strobe(8);
`endif
      rd_strobe(6);
      rd_strobe(7);
   endtask

   task automatic drain(input string name);
      expect_reg({name, "_level"}, 4, 16'(exp_q.size()));
      for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) pop_entry();
      expect_reg({name, "_level_zero"}, 4, 16'd0);
   endtask

   task automatic set_list_rand(input int n);
      logic [7:0] c;
      wr_reg(0, 16'h0004);
      ch_list.delete();
      poll_k = 0;
      for (int i = 0; i < n; i++) begin
         c = 8'($urandom_range(0, 255));
         wr_reg(3, {8'd0, c});
         ch_list.push_back(c);
      end
   endtask

   task automatic stop_run();
      wr_reg(0, 16'h0000);
      repeat (40) @(negedge sys_clk);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      int n;
      int waited;
      repeat (3) @(negedge sys_clk);
      #1;
      check("rst_output_sample", 48'(output_sample), 48'd0);
      check("rst_channel_select", 48'(channel_select), 48'd0);
      check("rst_data_out", 48'(data_out), 48'd0);
      @(negedge sys_clk);
      reset = 1'b0;
      expect_reg("rst_ctrl", 0, 16'd0);
      expect_reg("rst_period", 1, 16'd0);
      expect_reg("rst_nch", 2, 16'd0);
      expect_reg("rst_level", 4, 16'd0);
      expect_reg("rst_status", 5, 16'h0001);

      // Empty read of DATA_HI: returns 0 and must not underflow.
      rd_strobe(7);
      expect_reg("empty_read_level", 4, 16'd0);
      expect_reg("empty_read_status", 5, 16'h0001);

      // Basic two-channel scan with fixed producer data.
      fixed_mode = 1'b1;
      wr_reg(1, 16'd10);
      expect_reg("period_readback", 1, 16'd10);
      wr_reg(0, 16'h0004);
      ch_list.delete();
      poll_k = 0;
      wr_reg(3, 16'd100); ch_list.push_back(8'd100);
      wr_reg(3, 16'd3);   ch_list.push_back(8'd3);
      expect_reg("basic_nch", 2, 16'd2);
      wr_reg(0, 16'h0001);
      repeat (40) @(negedge sys_clk);
      stop_run();
      expect_reg("basic_level", 4, 16'(exp_q.size()));
      pop_entry();
      expect_reg("basic_level_dec", 4, 16'(exp_q.size()));
      drain("basic");
      fixed_mode = 1'b0;

      // Random lists and periods long enough to avoid overrun.
      for (int r = 0; r < 4; r++) begin
         n = $urandom_range(1, 6);
         set_list_rand(n);
         expect_reg("rand_nch", 2, 16'(n));
         wr_reg(1, 16'($urandom_range(2 * n + 1, 2 * n + 12)));
         wr_reg(0, 16'h0001);
         repeat ($urandom_range(60, 150)) @(negedge sys_clk);
         stop_run();
         drain("rand");
         expect_reg("rand_status", 5, 16'h0001);
      end

      // PERIOD=0 behaves as 1: ticks every cycle, so a one-channel scan overruns.
      set_list_rand(1);
      wr_reg(1, 16'd0);
      wr_reg(0, 16'h0001);
      repeat (20) @(negedge sys_clk);
      stop_run();
      expect_reg("period0_status", 5, 16'h0004);
      drain("period0");
      wr_reg(0, 16'h0002);
      expect_reg("period0_clear_status", 5, 16'h0001);

      // Full list, extra push ignored, scan overrun at PERIOD=20.
      set_list_rand(16);
      wr_reg(3, 16'd55);
      expect_reg("nch_saturate", 2, 16'd16);
      wr_reg(1, 16'd20);
      wr_reg(0, 16'h0001);
      repeat (200) @(negedge sys_clk);
      stop_run();
      expect_reg("overrun_status", 5, 16'h0004);
      drain("overrun");
      wr_reg(0, 16'h0002);
      expect_reg("overrun_clear_status", 5, 16'h0001);

      // FIFO overflow with no reads, then CLEAR.
      set_list_rand(1);
      wr_reg(1, 16'd4);
      wr_reg(0, 16'h0001);
      repeat (4300) @(negedge sys_clk);
      stop_run();
      expect_reg("full_level", 4, 16'(DEPTH));
      expect_reg("full_model_level", 4, 16'(exp_q.size()));
      expect_reg("full_status", 5, 16'h0006);
      wr_reg(0, 16'h0002);
      exp_q.delete();
      expect_reg("clear_level", 4, 16'd0);
      expect_reg("clear_status", 5, 16'h0001);

      // Holding re on DATA_HI for 5 cycles pops exactly once.
      set_list_rand(2);
      wr_reg(1, 16'd7);
      wr_reg(0, 16'h0001);
      repeat (30) @(negedge sys_clk);
      stop_run();
      expect_reg("hold_level", 4, 16'(exp_q.size()));
`ifdef SAMPLE_TIMESTAMP_EN
      rd_strobe(8);
`endif
      rd_strobe(6);
      @(negedge sys_clk);
      enable = 1'b1; re = 1'b1; addr = 19'(POS + 7);
      repeat (5) @(negedge sys_clk);
      enable = 1'b0; re = 1'b0;
      expect_reg("hold_one_pop", 4, 16'(exp_q.size()));
      drain("hold");

      // Reset asserted in the middle of a scan.
      set_list_rand(16);
      wr_reg(1, 16'd40);
      wr_reg(0, 16'h0001);
      waited = 0;
      while (!output_sample && waited < 200) begin
         @(negedge sys_clk);
         #1;
         waited++;
      end
      check("wait_for_poll", 48'(output_sample), 48'd1);
      @(posedge sys_clk);
      #1 reset = 1'b1;
      @(posedge sys_clk);
      #1;
      check("rst_mid_output_sample", 48'(output_sample), 48'd0);
      reset = 1'b0;
      exp_q.delete();
      ch_list.delete();
      poll_k = 0;
      scan_m = '0;
      expect_reg("rst_mid_nch", 2, 16'd0);
      expect_reg("rst_mid_level", 4, 16'd0);
      expect_reg("rst_mid_ctrl", 0, 16'd0);
      expect_reg("rst_mid_status", 5, 16'h0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
